scanline_buffer: RTL and testbench

SCANLINE_BUFFER -- requirements
Module: scanline_buffer

---
 rtl/scanline_buffer.sv | 123 ++++++++++++
 tb/tb_scanline_buffer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/scanline_buffer.sv
`default_nettype none
// ============================================================================
// Module      : scanline_buffer
// Description : Double-banked scanline buffer. The renderer fills one bank
//               while video timing reads the other; banks swap on lineStart
//               only when the fill bank holds a complete line.
// Revision    : 1.0 - initial release
// ============================================================================
module scanline_buffer #(
    parameter int         LINE_PIXELS = 256,
    parameter logic [5:0] BACKDROP    = 6'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] wrData,
    input  logic       wrValid,
    output logic       wrReady,
    input  logic       lineStart,
    input  logic       pixelEn,
    output logic [5:0] colourNum,
    output logic       underrun
);

    localparam int                c_ADDR_W    = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
    localparam logic [c_ADDR_W-1:0] c_WR_LAST = c_ADDR_W'(LINE_PIXELS - 1);
    localparam logic [c_ADDR_W:0]   c_RD_END  = (c_ADDR_W + 1)'(LINE_PIXELS);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } fill_state_t;

    fill_state_t         state_q,      state_d;
    logic                disp_sel_q,   disp_sel_d;
    logic                line_valid_q, line_valid_d;
    logic [c_ADDR_W-1:0] wr_addr_q,    wr_addr_d;
    logic [c_ADDR_W:0]   rd_addr_q,    rd_addr_d;
    logic [5:0]          colour_q,     colour_d;
    logic                underrun_q,   underrun_d;

    logic [5:0] bank_mem [2][LINE_PIXELS];

    logic       w_wr_fire;
    logic       w_rd_in_line;
    logic [5:0] w_rd_pixel;

    assign wrReady      = (state_q == FILL);
    assign w_wr_fire    = wrReady && wrValid;
    assign w_rd_in_line = (rd_addr_q < c_RD_END);
    assign w_rd_pixel   = bank_mem[disp_sel_q][rd_addr_q[c_ADDR_W-1:0]];

    // Fill bank is always the complement of the display bank, so a write and
    // a read in the same cycle never touch the same storage.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            bank_mem[~disp_sel_q][wr_addr_q] <= wrData;
        end
    end

    always_comb begin
        state_d      = state_q;
        disp_sel_d   = disp_sel_q;
        line_valid_d = line_valid_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        colour_d     = BACKDROP;
        underrun_d   = 1'b0;

        // Address holds at the last slot once the line is complete.
        if (w_wr_fire) begin
            if (wr_addr_q == c_WR_LAST) begin
                state_d = FULL;
            end else begin
                wr_addr_d = wr_addr_q + 1'b1;
            end
        end

        if (lineStart) begin
            rd_addr_d = '0;
            if (state_q == FULL) begin
                disp_sel_d   = ~disp_sel_q;
                line_valid_d = 1'b1;
                wr_addr_d    = '0;
                state_d      = FILL;
            end else begin
                line_valid_d = 1'b0;
                underrun_d   = 1'b1;
            end
        end else if (pixelEn) begin
            if (line_valid_q && w_rd_in_line) begin
                colour_d = w_rd_pixel;
            end
            if (w_rd_in_line) begin
                rd_addr_d = rd_addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FILL;
            disp_sel_q   <= 1'b0;
            line_valid_q <= 1'b0;
            wr_addr_q    <= '0;
            rd_addr_q    <= c_RD_END;
            colour_q     <= BACKDROP;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            disp_sel_q   <= disp_sel_d;
            line_valid_q <= line_valid_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            colour_q     <= colour_d;
            underrun_q   <= underrun_d;
        end
    end

    assign colourNum = colour_q;
    assign underrun  = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_scanline_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_scanline_buffer
// Description : Self-checking bench for scanline_buffer against a queue-based
//               line model (LINE_PIXELS=8, BACKDROP=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scanline_buffer;

    localparam int         c_LP = 8;
    localparam logic [5:0] c_BD = 6'h00;

    logic       clk;
    logic       reset;
    logic [5:0] wrData;
    logic       wrValid;
    logic       wrReady;
    logic       lineStart;
    logic       pixelEn;
    logic [5:0] colourNum;
    logic       underrun;

    int n_cmp;
    int n_err;

    // Reference model: accepted pixels queue, the line currently on display,
    // and how far into it the reader has got.
    logic [5:0] m_fill[$];
    logic [5:0] m_disp[c_LP];
    logic       m_valid;
    int         m_rd;

    scanline_buffer #(
        .LINE_PIXELS(c_LP),
        .BACKDROP   (c_BD)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .wrData   (wrData),
        .wrValid  (wrValid),
        .wrReady  (wrReady),
        .lineStart(lineStart),
        .pixelEn  (pixelEn),
        .colourNum(colourNum),
        .underrun (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fill.delete();
        m_valid = 1'b0;
        m_rd    = c_LP;
    endtask

    // One clock cycle: drive inputs after the falling edge, check the
    // combinational ready, then check registered outputs just after the edge.
    task automatic step(input logic ls, input logic pe, input logic wv, input logic [5:0] wd);
        logic       exp_ready;
        logic       accept;
        logic       was_full;
        logic [5:0] exp_col;
        logic       exp_under;
        @(negedge clk);
        lineStart = ls;
        pixelEn   = pe;
        wrValid   = wv;
        wrData    = wd;
        #1;
        was_full  = (m_fill.size() == c_LP);
        exp_ready = !was_full;
        accept    = wv && exp_ready;
        check_value("wrReady", wrReady, exp_ready);

        exp_col   = c_BD;
        exp_under = ls && !was_full;
        if (ls) begin
            m_rd = 0;
            if (was_full) begin
                for (int i = 0; i < c_LP; i++) m_disp[i] = m_fill[i];
                m_fill.delete();
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end else if (pe) begin
            if (m_valid && m_rd < c_LP) exp_col = m_disp[m_rd];
            if (m_rd < c_LP) m_rd++;
        end
        if (accept) m_fill.push_back(wd);

        @(posedge clk);
        #1;
        check_value("colourNum", colourNum, exp_col);
        check_value("underrun", underrun, exp_under);
    endtask

    task automatic fill_writes(input int n, input int base);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 6'(base + i));
    endtask

    task automatic read_pixels(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 6'($urandom));
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        wrData    = '0;
        wrValid   = 1'b0;
        lineStart = 1'b0;
        pixelEn   = 1'b0;
        model_reset();
        #1;
        check_value("reset_colour", colourNum, c_BD);
        check_value("reset_ready", wrReady, 1'b1);
        check_value("reset_under", underrun, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Full fill of 1..8, display it, then idle.
        fill_writes(8, 1);
        step(1'b1, 1'b0, 1'b0, 6'h0);
        read_pixels(8);
        step(1'b0, 1'b0, 1'b0, 6'h0);

        // Underrun after 5 writes, complete the fill, show it next line.
        fill_writes(5, 10);
        step(1'b1, 1'b0, 1'b0, 6'h0);
        read_pixels(8);
        fill_writes(3, 15);
        step(1'b1, 1'b0, 1'b0, 6'h0);
        read_pixels(8);

        // Over-read past the end of the line returns backdrop.
        fill_writes(8, 30);
        step(1'b1, 1'b0, 1'b0, 6'h0);
        read_pixels(10);

        // lineStart coincident with the completing write.
        fill_writes(7, 40);
        step(1'b1, 1'b0, 1'b1, 6'd47);
        read_pixels(3);
        step(1'b1, 1'b1, 1'b0, 6'h0);
        read_pixels(8);
        step(1'b1, 1'b1, 1'b0, 6'h0);

        // Random traffic with periodic line starts.
        for (int ln = 0; ln < 150; ln++) begin
            int len;
            len = $urandom_range(6, 20);
            for (int c = 0; c < len; c++) begin
                step(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 6'($urandom));
            end
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom));
        end

        // Asynchronous reset mid-line after 4 pixels have been read.
        fill_writes(8, 50);
        step(1'b1, 1'b0, 1'b0, 6'h0);
        read_pixels(4);
        @(negedge clk);
        pixelEn = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_value("async_colour", colourNum, c_BD);
        check_value("async_ready", wrReady, 1'b1);
        pixelEn = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        fill_writes(3, 60);
        step(1'b1, 1'b0, 1'b0, 6'h0);
        read_pixels(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
